adder8: RTL and testbench

ADDER8 -- requirements
Module: adder8

---
 rtl/adder8_pkg.sv | 28 ++
 rtl/adder8_stage.sv | 43 ++++
 rtl/adder8.sv | 78 +++++++
 tb/tb_adder8.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/adder8_pkg.sv
// -----------------------------------------------------------------------------
// adder8_pkg
// Shared constants for the adder8 slice:
//   ADDER8_WIDTH      default operand width
//   adder8_out_w()    result width for a given operand width (one carry bit)
//   ADDER8_LAT_NOREG  result latency without the input stage (cycles)
//   ADDER8_LAT_INREG  result latency with the input stage (cycles)
//   ADDER8_LATENCY    latency of the build being compiled
// Optional feature macro: ADDER8_INREG_EN (selects ADDER8_LATENCY).
// -----------------------------------------------------------------------------
package adder8_pkg;

  localparam int ADDER8_WIDTH     = 8;
  localparam int ADDER8_LAT_NOREG = 1;
  localparam int ADDER8_LAT_INREG = 2;

`ifdef ADDER8_INREG_EN
  localparam int ADDER8_LATENCY = ADDER8_LAT_INREG;
`else
  localparam int ADDER8_LATENCY = ADDER8_LAT_NOREG;
`endif

  // Unsigned sum of two width-bit operands never needs more than one extra bit.
  function automatic int adder8_out_w(input int width);
    return width + 1;
  endfunction

endpackage : adder8_pkg

// File: rtl/adder8_stage.sv
// -----------------------------------------------------------------------------
// adder8_stage
// Reset-able valid + data pipeline register, used for both the optional input
// stage and the output stage of adder8.
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset; clears valid and data to 0
//   i_valid  data on i_data is valid this cycle
//   i_data   W-bit payload
//   o_valid  registered i_valid
//   o_data   last payload captured with i_valid=1 (held otherwise)
// -----------------------------------------------------------------------------
module adder8_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // Data only loads on a valid beat, so an idle (possibly unknown) payload
  // never overwrites the held value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule : adder8_stage

// File: rtl/adder8.sv
// -----------------------------------------------------------------------------
// adder8
// Registered unsigned adder: y = a + b, zero-extended to OUT_W bits, carry is
// the MSB of y.
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears y, carry, out_valid)
//   a, b       WIDTH-bit unsigned operands
//   in_valid   operands valid this cycle
//   y          OUT_W-bit registered sum
//   out_valid  y holds a new result this cycle
//   carry      y[OUT_W-1]
// Optional feature macro: ADDER8_INREG_EN adds an input register stage
// (latency 2 instead of 1).
//
// Handshake: valid-only, no ready. A beat is accepted on every rising edge
// where in_valid=1; each accepted beat produces exactly one out_valid=1 cycle
// after the fixed latency, in order. When out_valid=0, y/carry hold the last
// result.
// -----------------------------------------------------------------------------
module adder8
  import adder8_pkg::*;
#(
  parameter int WIDTH = ADDER8_WIDTH,
  parameter int OUT_W = adder8_out_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [OUT_W-1:0] y,
  output logic             out_valid,
  output logic             carry
);

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_valid;
  logic [OUT_W-1:0] w_sum;
  logic [OUT_W-1:0] w_y;

`ifdef ADDER8_INREG_EN
  logic [2*WIDTH-1:0] w_ab_q;

  adder8_stage #(.W(2*WIDTH)) u_in_stage (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (in_valid),
    .i_data  ({a, b}),
    .o_valid (w_valid),
    .o_data  (w_ab_q)
  );

  assign w_a = w_ab_q[2*WIDTH-1:WIDTH];
  assign w_b = w_ab_q[WIDTH-1:0];
`else
  assign w_a     = a;
  assign w_b     = b;
  assign w_valid = in_valid;
`endif

  // Zero-extend before adding so the carry lands in the extra bit.
  assign w_sum = OUT_W'(w_a) + OUT_W'(w_b);

  adder8_stage #(.W(OUT_W)) u_out_stage (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_valid),
    .i_data  (w_sum),
    .o_valid (out_valid),
    .o_data  (w_y)
  );

  assign y     = w_y;
  // Taken from the registered result, so it is registered with y by construction.
  assign carry = w_y[OUT_W-1];

endmodule : adder8

// File: tb/tb_adder8.sv
module tb_adder8;

  localparam int W  = 8;
  localparam int OW = 9;

`ifdef ADDER8_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic          clk;
  logic          rst_n;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          in_valid;
  logic [OW-1:0] y;
  logic          out_valid;
  logic          carry;

  int cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  adder8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .y         (y),
    .out_valid (out_valid),
    .carry     (carry)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [OW-1:0] exp_q[$];
  int            due_q[$];
  logic [OW-1:0] exp_hold = '0;
  int            compared = 0;
  int            mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [OW-1:0] texp);
    @(negedge clk);
    a        = ta;
    b        = tb;
    in_valid = 1'b1;
    exp_q.push_back(texp);
    due_q.push_back(cyc + LAT);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    a        = 'x;
    b        = 'x;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: samples on the falling edge, away from the active edge
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic [OW-1:0] e;
    int            d;
    if (!rst_n) begin
      check("reset_y", 32'(y), 32'd0);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_carry", 32'(carry), 32'd0);
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        d = due_q.pop_front();
        check("y", 32'(y), 32'(e));
        check("carry", 32'(carry), 32'(e[OW-1]));
        check("latency_cycle", 32'(cyc), 32'(d));
        exp_hold = e;
      end
    end else begin
      check("hold_y", 32'(y), 32'(exp_hold));
      check("hold_carry", 32'(carry), 32'(exp_hold[OW-1]));
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        check("missing_out_valid", 32'(out_valid), 32'd1);
        e = exp_q.pop_front();
        d = due_q.pop_front();
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus (expected sums computed by hand)
  // ---------------------------------------------------------------------------
  initial begin
    rst_n    = 1'b0;
    a        = '0;
    b        = '0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle();

    // zero operands
    drive(8'd0, 8'd0, 9'd0);
    idle();

    // back-to-back stream
    drive(8'd10, 8'd20, 9'd30);
    drive(8'd19, 8'd2,  9'd21);
    drive(8'd30, 8'd2,  9'd32);
    drive(8'd5,  8'd7,  9'd12);
    idle();

    // carry-out boundaries
    drive(8'd255, 8'd255, 9'd510);
    drive(8'd255, 8'd1,   9'd256);
    drive(8'd128, 8'd128, 9'd256);
    drive(8'd0,   8'd255, 9'd255);
    idle();

    // two-cycle gap with unknown operands while idle
    drive(8'd1, 8'd1, 9'd2);
    idle();
    idle();
    drive(8'd2, 8'd2, 9'd4);
    idle();
    repeat (LAT + 1) @(negedge clk);

    // reset asserted with a transaction in flight
    drive(8'd7, 8'd8, 9'd15);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    due_q.delete();
    exp_hold = '0;
    #1;
    check("async_reset_y", 32'(y), 32'd0);
    check("async_reset_out_valid", 32'(out_valid), 32'd0);
    check("async_reset_carry", 32'(carry), 32'd0);
    // operands presented during reset must be discarded
    a = 8'd9;
    b = 8'd9;
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    idle();
    idle();
    idle();
    drive(8'd100, 8'd27, 9'd127);
    idle();

    // drain with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      check("drain_pending", 32'(exp_q.size()), 32'd0);
    end
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_adder8
